// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared pixel/frame memory bus (display read / CPU write).
// Optional ack timeout with master lockout: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned ADDW = 18,
    parameter int unsigned DBUS = 16,
    parameter int unsigned TMO  = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [1:0]      m0_sel_i,
    input  logic [ADDW-1:0] m0_adr_i,
    input  logic [DBUS-1:0] m0_dat_i,
    output logic [DBUS-1:0] m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_busy_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [1:0]      m1_sel_i,
    input  logic [ADDW-1:0] m1_adr_i,
    input  logic [DBUS-1:0] m1_dat_i,
    output logic [DBUS-1:0] m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_busy_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [1:0]      s_sel_o,
    output logic [ADDW-1:0] s_adr_o,
    output logic [DBUS-1:0] s_dat_o,
    input  logic [DBUS-1:0] s_dat_i,
    input  logic            s_ack_i
);

    if (TMO < 1 || TMO > 255) begin : g_bad_tmo
        $error("mem_bus_arbiter: TMO must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   req0, req1;
    logic   lock0, lock1;
    logic   tmo_hit;

    // A locked-out master does not count as requesting until it drops cyc.
    assign req0 = m0_cyc_i & ~lock0;
    assign req1 = m1_cyc_i & ~lock1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? GNT0 : GNT1;
                else if (req0)
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (tmo_hit) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end else if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (tmo_hit) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end else if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = req0 ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave side follows the granted master's live inputs, so release cycles drop s_cyc_o at once.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m0_ack_o  = (state == GNT0) & s_ack_i;
    assign m1_ack_o  = (state == GNT1) & s_ack_i;
    assign m0_busy_o = (state == GNT1);
    assign m1_busy_o = (state == GNT0);
    assign m0_err_o  = tmo_hit & (state == GNT0);
    assign m1_err_o  = tmo_hit & (state == GNT1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_L = 8'(TMO);

    logic [7:0] tmo_cnt;

    assign tmo_hit = (state != IDLE) && s_stb_o && !s_ack_i && (tmo_cnt == TMO_L);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if ((state == IDLE) || (state_nxt != state) || !s_stb_o || s_ack_i)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock0 <= 1'b0;
            lock1 <= 1'b0;
        end else begin
            if (m0_err_o)
                lock0 <= 1'b1;
            else if (!m0_cyc_i)
                lock0 <= 1'b0;
            if (m1_err_o)
                lock1 <= 1'b1;
            else if (!m1_cyc_i)
                lock1 <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign lock0   = 1'b0;
    assign lock1   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter; timeout checks follow MEM_ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [1:0]  m0_sel_i;
    logic [17:0] m0_adr_i;
    logic [15:0] m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_busy_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [1:0]  m1_sel_i;
    logic [17:0] m1_adr_i;
    logic [15:0] m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_busy_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [1:0]  s_sel_o;
    logic [17:0] s_adr_o;
    logic [15:0] s_dat_o, s_dat_i;
    logic        s_ack_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_bus_arbiter #(.ADDW(18), .DBUS(16), .TMO(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_busy_o(m0_busy_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_busy_o(m1_busy_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int errs;
        int first;

        rst_i = 1'b1;
        {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i} = '0;
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i} = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;

        // reset state
        @(negedge clk_i);
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_busy", 32'({m0_busy_o, m1_busy_o}), 0);

        // single master grant and routing
        tick();
        rst_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_sel_i = 2'b11; m0_adr_i = 18'h00123; m0_dat_i = 16'hBEEF;
        @(negedge clk_i);
        chk("t1_idle_busy", 32'(m1_busy_o), 0);
        chk("t1_idle_scyc", 32'(s_cyc_o), 0);
        tick();
        @(negedge clk_i);
        chk("t1_busy", 32'({m0_busy_o, m1_busy_o}), 32'b01);
        chk("t1_adr", 32'(s_adr_o), 32'h123);
        chk("t1_dat", 32'(s_dat_o), 32'hBEEF);
        chk("t1_ctl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'b11111);
        s_ack_i = 1'b1; s_dat_i = 16'h5A5A;
        #1;
        chk("t1_ack", 32'({m0_ack_o, m1_ack_o}), 32'b10);
        chk("t1_rdat", 32'({m0_dat_o, m1_dat_o}), 32'h5A5A5A5A);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        chk("t1_rel_scyc", 32'(s_cyc_o), 0);
        chk("t1_rel_busy", 32'(m1_busy_o), 1);
        tick();
        @(negedge clk_i);
        chk("t1_idle_after", 32'(m1_busy_o), 0);

        // ties after reset, handoff, and second tie
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("t2_tie1", 32'({m0_busy_o, m1_busy_o}), 32'b01);
        tick();
        m0_cyc_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("t2_handoff", 32'({m0_busy_o, m1_busy_o}), 32'b10);
        tick();
        m1_cyc_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("t2_tie2", 32'({m0_busy_o, m1_busy_o}), 32'b01);
        tick();
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();

        // long m1 tenure while m0 waits
        m1_cyc_i = 1'b1;
        tick();
        m0_cyc_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (m0_busy_o) cnt++;
            tick();
        end
        chk("t3_busy40", 32'(cnt), 40);
        m1_cyc_i = 1'b0;
        @(negedge clk_i);
        chk("t3_rel_busy", 32'(m0_busy_o), 1);
        tick();
        @(negedge clk_i);
        chk("t3_m0_gnt", 32'({m0_busy_o, m1_busy_o, s_cyc_o}), 32'b011);

        // asynchronous reset mid-tenure
        tick();
        m0_cyc_i = 1'b0;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
        m1_sel_i = 2'b01; m1_adr_i = 18'h3ABCD; m1_dat_i = 16'h1234;
        tick();
        #1;
        chk("t4_pre_adr", 32'(s_adr_o), 32'h3ABCD);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t4_async_ctl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 0);
        chk("t4_async_bus", 32'({s_adr_o, s_dat_o[13:0]}), 0);
        chk("t4_async_busy", 32'({m0_busy_o, m1_busy_o}), 0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("t4_idle", 32'({m0_busy_o, m1_busy_o, s_cyc_o}), 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // ack timeout with TMO=4, then lockout
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        errs = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (m0_err_o) begin
                errs++;
                if (first < 0) first = i;
            end
            tick();
        end
        chk("t5_err_at", 32'(first), 4);
        chk("t5_err_cnt", 32'(errs), 1);
        @(negedge clk_i);
        chk("t5_locked", 32'({m1_busy_o, s_cyc_o}), 0);
        tick();
        m1_cyc_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("t5_m1_gnt", 32'({m0_busy_o, m1_busy_o}), 32'b10);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("t5_unlock", 32'({m0_busy_o, m1_busy_o}), 32'b01);
        tick();
        m0_cyc_i = 1'b0;
        tick();
`else
        // no timeout: grant held indefinitely
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk_i);
            if (m1_busy_o && !m0_busy_o && !m0_err_o && !m1_err_o) cnt++;
            tick();
        end
        chk("t5_hold120", 32'(cnt), 120);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the shared 16-bit pixel/frame memory bus. Master 0 is the display read path (frame renderer); master 1 is the CPU/blitter write path. The block grants exactly one master at a time, muxes its strobe, address, data and select lanes onto the single memory slave, and routes data and acknowledges back. It also drives each master's "bus busy" input, so the renderer's bus-wait condition is sourced here.

## Interface
Parameters:
- ADDW, 18, address width
- DBUS, 16, data width
- TMO, 255, ack-timeout limit in cycles (used only with MEM_ARB_TIMEOUT_EN); must be ≥1 and fit in 8 bits

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous and active-high
- mN_cyc_i  in  1  master N (N=0,1) bus request, held for the whole tenure
- mN_stb_i  in  1  master N transfer strobe
- mN_we_i  in  1  master N write enable
- mN_sel_i  in  2  master N byte selects
- mN_adr_i  in  ADDW  master N address
- mN_dat_i  in  DBUS  master N write data
- mN_dat_o  out  DBUS  read data to master N
- mN_ack_o  out  1  acknowledge to master N
- mN_busy_o  out  1  bus currently granted to the other master
- mN_err_o  out  1  one-cycle timeout abort pulse
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_sel_o  out  2  to slave
- s_adr_o  out  ADDW  to slave
- s_dat_o  out  DBUS  to slave
- s_dat_i  in  DBUS  slave read data
- s_ack_i  in  1  slave acknowledge

## Operation
- States: IDLE, GNT0, GNT1. Register `last` records the last granted master; reset value 1, so master 0 wins the first tie.
- IDLE: if exactly one mN_cyc_i is high, go to GNTN. If both are high, grant the master that is not `last`. If neither, stay in IDLE.
- GNTN: hold while mN_cyc_i=1. When mN_cyc_i=0, set last=N. Then go to GNT(other) if the other cyc_i is high, else IDLE. A master never loses the grant while its cyc_i is high.
- Slave outputs are combinational muxes of the granted master's inputs. In IDLE: s_cyc_o, s_stb_o and s_we_o are 0; s_sel_o, s_adr_o and s_dat_o are 0.
- s_ack_i is routed only to the granted master. The non-granted mN_ack_o is forced to 0.
- s_dat_i fans out to both mN_dat_o unconditionally.
- mN_busy_o=1 exactly while state is GNT(other).
- Reset (asynchronous, any time including mid-transfer): state=IDLE, last=1, timeout counter=0, lockout flags=0. All outputs read 0, since slave controls fall to 0 in IDLE.

## Timing
- Grant latency: cyc_i rises in cycle k (bus IDLE). The state is GNT from edge k+1, and the slave sees the master's stb and address in cycle k+1.
- Ack path is combinational: s_ack_i in cycle j gives mN_ack_o in cycle j. The master samples data at the same edge.
- Handoff: the owner drops cyc in cycle k while the other requests. The other is granted from edge k+1, with no idle gap.
- The release cycle itself drives s_cyc_o=0, because the mux follows the live cyc_i.
- Simultaneous release by the owner and first request by the other in the same cycle: handoff per the rule above.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs while the granted master has stb=1 and s_ack_i=0. It clears on ack, on stb=0 and on a grant change.
  - When the count reaches TMO, mN_err_o pulses for 1 cycle, the state is forced to IDLE, and master N enters lockout.
  - A master in lockout is ignored for arbitration until its cyc_i is seen low.
- MEM_ARB_TIMEOUT_EN undefined: no counter and no lockout. mN_err_o is tied to 0, and the grant is held indefinitely.

## Test plan
- Reset, then m0_cyc_i=1 alone: m0_busy_o stays 0 and m1_busy_o=1 from the next edge. s_adr_o equals m0_adr_i (e.g. 0x00123), and s_ack_i is echoed only on m0_ack_o.
- Both masters raise cyc in the same cycle after reset: m0 is granted first. After m0 drops cyc, m1 is granted on the next edge. A second tie then goes to m0, because last=1.
- m1 holds cyc for 40 cycles while m0 requests: m0_busy_o=1 throughout, and m0 is granted the edge after m1 releases.
- Assert rst_i mid-tenure, with m1 granted, stb=1 and no ack: all s_* outputs are 0 immediately, without waiting for a clock edge. After release with no requests, the state is IDLE.
- With MEM_ARB_TIMEOUT_EN and TMO=4: m0 strobes and the slave never acks. m0_err_o pulses exactly 4 cycles after the stb cycle and the bus goes IDLE. m0 is not regranted while its cyc stays high; m1 can be granted.
- Without the macro, same stimulus: no err pulse, and the grant is held for 100+ cycles.
